// File: rtl/axi_arb_pkg.sv
// rtl/axi_arb_pkg.sv - shared types and constants for the cache-side AXI arbiter
package axi_arb_pkg;

    localparam int         LEN_W_DEF = 4;
    localparam logic [3:0] SEL_FULL  = 4'hF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IREAD  = 2'd1,
        DREAD  = 2'd2,
        DWRITE = 2'd3
    } arb_state_t;

    // Class that gets first pick at the next IDLE arbitration
    typedef enum logic {
        RR_I = 1'b0,
        RR_D = 1'b1
    } rr_class_t;

endpackage

// File: rtl/burst_beat_counter.sv
// rtl/burst_beat_counter.sv - read beat counter, cleared on grant, flags the final beat
module burst_beat_counter
    import axi_arb_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic             inc,
    input  logic [LEN_W-1:0] len,
    output logic             last
);

    logic [LEN_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign last = (cnt == len);

endmodule

// File: rtl/axi_cache_arbiter.sv
// rtl/axi_cache_arbiter.sv - arbitrates ICache refill, DCache refill and DCache write-back onto one AXI port
module axi_cache_arbiter
    import axi_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              flush,
    input  logic              i_ren,
    input  logic [ADDR_W-1:0] i_raddr,
    input  logic [LEN_W-1:0]  i_rlen,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_rvalid,
    input  logic              d_ren,
    input  logic [ADDR_W-1:0] d_raddr,
    input  logic [LEN_W-1:0]  d_rlen,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_rvalid,
    input  logic              d_wen,
    input  logic [ADDR_W-1:0] d_waddr,
    input  logic [LEN_W-1:0]  d_wlen,
    input  logic [3:0]        d_wsel,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic              d_wvalid,
    input  logic              d_wlast,
    output logic              d_bvalid,
    output logic              axi_ce_o,
    output logic              axi_ren_o,
    output logic              axi_wen_o,
    output logic [3:0]        axi_sel_o,
    output logic [ADDR_W-1:0] axi_raddr_o,
    output logic [ADDR_W-1:0] axi_waddr_o,
    output logic [LEN_W-1:0]  axi_rlen_o,
    output logic [LEN_W-1:0]  axi_wlen_o,
    output logic [DATA_W-1:0] axi_wdata_o,
    output logic              axi_wvalid_o,
    output logic              axi_wlast_o,
    output logic              axi_rready_o,
    input  logic [DATA_W-1:0] axi_rdata_i,
    input  logic              axi_rvalid_i,
    input  logic              axi_bvalid_i
);

    arb_state_t        state;
    arb_state_t        grant_state;
    rr_class_t         rr_ptr;
    logic              squash;
    logic [ADDR_W-1:0] lat_addr;
    logic [LEN_W-1:0]  lat_len;
    logic [ADDR_W-1:0] grant_addr;
    logic [LEN_W-1:0]  grant_len;
    logic              rd_state;
    logic              beat;
    logic              beat_last;
    logic              rd_done;
    logic              wr_done;
    logic              load;

    assign rd_state = (state == IREAD) || (state == DREAD);
    assign beat     = rd_state && axi_rvalid_i;
    assign rd_done  = beat && beat_last;
    assign wr_done  = (state == DWRITE) && axi_bvalid_i;
    assign load     = (state == IDLE) && (grant_state != IDLE);

    // Preferred class goes first; inside D a pending write-back beats a refill
    always_comb begin
        grant_state = IDLE;
        grant_addr  = '0;
        grant_len   = '0;
        if (rr_ptr == RR_I && i_ren) begin
            grant_state = IREAD;
            grant_addr  = i_raddr;
            grant_len   = i_rlen;
        end else if (d_wen) begin
            grant_state = DWRITE;
            grant_addr  = d_waddr;
            grant_len   = d_wlen;
        end else if (d_ren) begin
            grant_state = DREAD;
            grant_addr  = d_raddr;
            grant_len   = d_rlen;
        end else if (i_ren) begin
            grant_state = IREAD;
            grant_addr  = i_raddr;
            grant_len   = i_rlen;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state    <= IDLE;
            rr_ptr   <= RR_D;
            squash   <= 1'b0;
            lat_addr <= '0;
            lat_len  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    squash <= 1'b0;
                    if (grant_state != IDLE) begin
                        state    <= grant_state;
                        lat_addr <= grant_addr;
                        lat_len  <= grant_len;
                    end
                end
                IREAD: begin
                    // A flushed refill still drains; only its delivery to the ICache stops
                    if (flush) begin
                        squash <= 1'b1;
                    end
                    if (rd_done) begin
                        state  <= IDLE;
                        rr_ptr <= RR_D;
                    end
                end
                DREAD: begin
                    if (rd_done) begin
                        state  <= IDLE;
                        rr_ptr <= RR_I;
                    end
                end
                DWRITE: begin
                    if (wr_done) begin
                        state  <= IDLE;
                        rr_ptr <= RR_I;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    burst_beat_counter #(
        .LEN_W (LEN_W)
    ) u_beat_counter (
        .clk    (aclk),
        .resetn (aresetn),
        .load   (load),
        .inc    (beat),
        .len    (lat_len),
        .last   (beat_last)
    );

    always_comb begin
        axi_ce_o     = 1'b0;
        axi_ren_o    = 1'b0;
        axi_wen_o    = 1'b0;
        axi_sel_o    = 4'h0;
        axi_raddr_o  = '0;
        axi_waddr_o  = '0;
        axi_rlen_o   = '0;
        axi_wlen_o   = '0;
        axi_wdata_o  = '0;
        axi_wvalid_o = 1'b0;
        axi_wlast_o  = 1'b0;
        axi_rready_o = 1'b0;
        i_rdata      = '0;
        i_rvalid     = 1'b0;
        d_rdata      = '0;
        d_rvalid     = 1'b0;
        d_bvalid     = 1'b0;
        case (state)
            IREAD, DREAD: begin
                axi_ce_o     = 1'b1;
                axi_ren_o    = 1'b1;
                axi_rready_o = 1'b1;
                axi_sel_o    = SEL_FULL;
                axi_raddr_o  = lat_addr;
                axi_rlen_o   = lat_len;
                if (state == IREAD) begin
                    i_rdata  = axi_rdata_i;
                    i_rvalid = axi_rvalid_i && !squash;
                end else begin
                    d_rdata  = axi_rdata_i;
                    d_rvalid = axi_rvalid_i;
                end
            end
            DWRITE: begin
                axi_ce_o     = 1'b1;
                axi_wen_o    = 1'b1;
                axi_sel_o    = d_wsel;
                axi_waddr_o  = lat_addr;
                axi_wlen_o   = lat_len;
                axi_wdata_o  = d_wdata;
                axi_wvalid_o = d_wvalid;
                axi_wlast_o  = d_wlast;
                d_bvalid     = axi_bvalid_i;
            end
            default: ;
        endcase
    end

endmodule
